video_scandoubler: RTL

Line-doubling stage placed directly upstream of the OSD overlay in the video path. It buffers each incoming 15 kHz core line in on-chip RAM and plays it back twice at double pixel rate, producing 31 kHz VGA-compatible RGB and syncs that the OSD stage then consumes. An optional scanline effect darkens every second output line, and a bypass mode passes the core video through unchanged. Input and output are both in the `clk_sys` domain and are paced by pixel clock enables.

---
 rtl/video_scandoubler_if.sv | 30 +++
 rtl/video_scandoubler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/video_scandoubler_if.sv
// Video port bundle for the scandoubler: core-side pixel/sync inputs and doubled outputs.
// Both directions are paced by the ce_x1/ce_x2 pixel enables.
interface video_scandoubler_if #(
  parameter int COLOR_W = 8
);
  logic               ce_x1;
  logic               ce_x2;
  logic               enable;
  logic [1:0]         scanlines;
  logic [COLOR_W-1:0] R_in;
  logic [COLOR_W-1:0] G_in;
  logic [COLOR_W-1:0] B_in;
  logic               HSync_in;
  logic               VSync_in;
  logic [COLOR_W-1:0] R_out;
  logic [COLOR_W-1:0] G_out;
  logic [COLOR_W-1:0] B_out;
  logic               HSync_out;
  logic               VSync_out;

  modport master (
    output ce_x1, ce_x2, enable, scanlines, R_in, G_in, B_in, HSync_in, VSync_in,
    input  R_out, G_out, B_out, HSync_out, VSync_out
  );

  modport slave (
    input  ce_x1, ce_x2, enable, scanlines, R_in, G_in, B_in, HSync_in, VSync_in,
    output R_out, G_out, B_out, HSync_out, VSync_out
  );
endinterface

// File: rtl/video_scandoubler.sv
// Line doubler: stores each 15 kHz core line in a ping-pong buffer and replays it twice
// at ce_x2 rate, with optional scanline darkening and a ce_x1-registered bypass path.
module video_scandoubler #(
  parameter int HCNT_W  = 10,
  parameter int COLOR_W = 8
) (
  input  logic               clk_sys,
  input  logic               reset,
  video_scandoubler_if.slave vid
);
  localparam int CNT_W = HCNT_W + 1;
  localparam int PIX_W = 3 * COLOR_W;
  localparam int DEPTH = 1 << HCNT_W;
  localparam logic [CNT_W-1:0] CAP     = {1'b1, {HCNT_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [COLOR_W-1:0] dim(input logic [COLOR_W-1:0] c, input logic [1:0] mode);
    logic [COLOR_W-1:0] res;
    case (mode)
      2'b01:   res = c - (c >> 2'd2);
      2'b10:   res = c >> 2'd1;
      2'b11:   res = c >> 2'd2;
      default: res = c;
    endcase
    return res;
  endfunction

  logic [PIX_W-1:0]   line_buf [0:2*DEPTH-1];
  logic [PIX_W-1:0]   rd_data_r;
  logic               rd_oob_r;
  logic               hs_in_d_r;
  logic [CNT_W-1:0]   hin_r;
  logic [CNT_W-1:0]   line_len_r;
  logic [CNT_W-1:0]   hs_cnt_r;
  logic [CNT_W-1:0]   hs_len_r;
  logic [CNT_W-1:0]   hout_r;
  logic               wbank_r;
  logic               odd_r;
  logic               vs_line_r;
  logic               valid_r;
  logic [COLOR_W-1:0] r_out_r, g_out_r, b_out_r;
  logic               hs_out_r, vs_out_r;

  logic               line_start_s;
  logic               hs_rise_s;
  logic [CNT_W-1:0]   hin_inc_s;
  logic [CNT_W-1:0]   hs_cnt_inc_s;
  logic [CNT_W-1:0]   wr_addr_s;
  logic               wr_bank_s;
  logic               wr_en_s;
  logic [CNT_W-1:0]   hout_nxt_s;
  logic               odd_nxt_s;
  logic [HCNT_W:0]    rd_addr_s;
  logic [PIX_W-1:0]   pix_s;
  logic [COLOR_W-1:0] dbl_r_s, dbl_g_s, dbl_b_s;

  assign line_start_s = vid.ce_x1 & hs_in_d_r & ~vid.HSync_in;
  assign hs_rise_s    = vid.ce_x1 & ~hs_in_d_r & vid.HSync_in;

  // Input side: saturating counters and the write slot; the line-start pixel opens the new bank at column 0
  always_comb begin
    hin_inc_s    = hin_r;
    hs_cnt_inc_s = hs_cnt_r;
    if (hin_r != CNT_MAX) begin
      hin_inc_s = hin_r + CNT_ONE;
    end else begin
      hin_inc_s = hin_r;
    end
    if (hs_cnt_r != CNT_MAX) begin
      hs_cnt_inc_s = hs_cnt_r + CNT_ONE;
    end else begin
      hs_cnt_inc_s = hs_cnt_r;
    end
    wr_addr_s = line_start_s ? {CNT_W{1'b0}} : hin_inc_s;
    wr_bank_s = line_start_s ? ~wbank_r : wbank_r;
    wr_en_s   = vid.ce_x1 & (wr_addr_s < CAP);
  end

  // Output position: line start beats the end-of-copy wrap
  always_comb begin
    hout_nxt_s = hout_r;
    odd_nxt_s  = odd_r;
    if (line_start_s) begin
      hout_nxt_s = {CNT_W{1'b0}};
      odd_nxt_s  = 1'b0;
    end else if (vid.ce_x2) begin
      if (hout_r == line_len_r) begin
        hout_nxt_s = {CNT_W{1'b0}};
        odd_nxt_s  = ~odd_r;
      end else begin
        hout_nxt_s = hout_r + CNT_ONE;
        odd_nxt_s  = odd_r;
      end
    end else begin
      hout_nxt_s = hout_r;
      odd_nxt_s  = odd_r;
    end
    rd_addr_s = {~wr_bank_s, hout_nxt_s[HCNT_W-1:0]};
  end

  // Line buffer: the read bank is always the one not being written, so ports never collide
  always_ff @(posedge clk_sys) begin
    if (wr_en_s) begin
      line_buf[{wr_bank_s, wr_addr_s[HCNT_W-1:0]}] <= {vid.R_in, vid.G_in, vid.B_in};
    end
    if (vid.ce_x2) begin
      rd_data_r <= line_buf[rd_addr_s];
    end
  end

  // Input-line bookkeeping: pixel count, hsync width, bank swap, vsync latch
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_in_d_r  <= 1'b0;
      hin_r      <= {CNT_W{1'b0}};
      line_len_r <= {CNT_W{1'b0}};
      hs_cnt_r   <= {CNT_W{1'b0}};
      hs_len_r   <= {CNT_W{1'b0}};
      wbank_r    <= 1'b0;
      vs_line_r  <= 1'b0;
      valid_r    <= 1'b0;
    end else if (vid.ce_x1) begin
      hs_in_d_r <= vid.HSync_in;
      hin_r     <= wr_addr_s;
      wbank_r   <= wr_bank_s;
      if (line_start_s) begin
        line_len_r <= hin_r;
        vs_line_r  <= vid.VSync_in;
        valid_r    <= 1'b1;
      end
      if (!vid.HSync_in) begin
        hs_cnt_r <= hs_in_d_r ? CNT_ONE : hs_cnt_inc_s;
      end
      if (hs_rise_s) begin
        hs_len_r <= hs_cnt_r;
      end
    end
  end

  // Output position registers, plus the out-of-range flag that travels with the read data
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hout_r   <= {CNT_W{1'b0}};
      odd_r    <= 1'b0;
      rd_oob_r <= 1'b0;
    end else if (vid.ce_x2) begin
      hout_r   <= hout_nxt_s;
      odd_r    <= odd_nxt_s;
      rd_oob_r <= (hout_nxt_s >= CAP);
    end
  end

  // Scanline darkening applies to the second copy of each line only
  always_comb begin
    pix_s = rd_oob_r ? {PIX_W{1'b0}} : rd_data_r;
    if (odd_r) begin
      dbl_r_s = dim(pix_s[3*COLOR_W-1:2*COLOR_W], vid.scanlines);
      dbl_g_s = dim(pix_s[2*COLOR_W-1:COLOR_W], vid.scanlines);
      dbl_b_s = dim(pix_s[COLOR_W-1:0], vid.scanlines);
    end else begin
      dbl_r_s = pix_s[3*COLOR_W-1:2*COLOR_W];
      dbl_g_s = pix_s[2*COLOR_W-1:COLOR_W];
      dbl_b_s = pix_s[COLOR_W-1:0];
    end
  end

  // Output registers: doubled path on ce_x2, bypass on ce_x1, idle until the first line start
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_out_r  <= {COLOR_W{1'b0}};
      g_out_r  <= {COLOR_W{1'b0}};
      b_out_r  <= {COLOR_W{1'b0}};
      hs_out_r <= 1'b1;
      vs_out_r <= 1'b1;
    end else if (valid_r) begin
      if (vid.enable) begin
        if (vid.ce_x2) begin
          r_out_r  <= dbl_r_s;
          g_out_r  <= dbl_g_s;
          b_out_r  <= dbl_b_s;
          hs_out_r <= ~(hout_r < hs_len_r);
          vs_out_r <= vs_line_r;
        end
      end else if (vid.ce_x1) begin
        r_out_r  <= vid.R_in;
        g_out_r  <= vid.G_in;
        b_out_r  <= vid.B_in;
        hs_out_r <= vid.HSync_in;
        vs_out_r <= vid.VSync_in;
      end
    end
  end

  assign vid.R_out     = r_out_r;
  assign vid.G_out     = g_out_r;
  assign vid.B_out     = b_out_r;
  assign vid.HSync_out = hs_out_r;
  assign vid.VSync_out = vs_out_r;
endmodule
